// File: rtl/fu_dispatch_ctrl_pkg.sv
// fu_dispatch_ctrl_pkg: op/state encodings and defaults shared by the FU dispatcher
package fu_dispatch_ctrl_pkg;
  localparam logic [1:0] OP_EXP = 2'd0;
  localparam logic [1:0] OP_RECIP = 2'd1;
  localparam logic [1:0] OP_REQUANT = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic logic [2:0] op_onehot(input logic [1:0] op);
    return op == OP_EXP ? 3'b001 : op == OP_RECIP ? 3'b010 : op == OP_REQUANT ? 3'b100 : 3'b000;
  endfunction
endpackage

// File: rtl/fu_dispatch_ctrl_watchdog.sv
// fu_watchdog: counts enabled cycles since clear and flags the last allowed cycle
module fu_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TO_W-1:0] count;
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable) count <= count + 1'b1;
  end
  assign expired = count == TO_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/fu_dispatch_ctrl.sv
// fu_dispatch_ctrl: issues one op to the exp/recip/requant units and returns result or error
module fu_dispatch_ctrl
  import fu_dispatch_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W = 7,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg0,
  input  logic [31:0] cmd_arg1,
  input  logic [31:0] cmd_arg2,
  output logic [31:0] fu_arg0,
  output logic [31:0] fu_arg1,
  output logic [31:0] fu_arg2,
  output logic [2:0]  fu_start,
  input  logic [2:0]  fu_done,
  input  logic [95:0] fu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  err_count
);
  state_t state;
  logic [1:0] op_q;
  logic expired, done_sel;
  logic [31:0] res_sel;
  fu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_wd (
    .clk(clk),
    .reset(reset),
    .clear(state == ISSUE),
    .enable(state == WAIT),
    .expired(expired)
  );
  always_comb begin
    done_sel = |(fu_done & op_onehot(op_q));
    res_sel = op_q == OP_RECIP ? fu_result[63:32] : op_q == OP_REQUANT ? fu_result[95:64] : fu_result[31:0];
  end
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q <= OP_EXP;
      fu_start <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      fu_arg0 <= '0;
      fu_arg1 <= '0;
      fu_arg2 <= '0;
      err_count <= '0;
    end else begin
      fu_start <= '0;
      unique case (state)
        IDLE: if (cmd_valid) begin
          op_q <= cmd_op;
          fu_arg0 <= cmd_arg0;
          fu_arg1 <= cmd_arg1;
          fu_arg2 <= cmd_arg2;
          if (cmd_op == OP_ILLEGAL) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_data <= ERR_DATA;
            err_count <= err_count + {7'd0, err_count != 8'hFF};
          end else begin
            state <= ISSUE;
            fu_start <= op_onehot(cmd_op);
          end
        end
        ISSUE: state <= WAIT;
        // done takes priority over a coincident watchdog expiry
        WAIT: if (done_sel) begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_data <= res_sel;
        end else if (expired) begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b1;
          rsp_data <= ERR_DATA;
          err_count <= err_count + {7'd0, err_count != 8'hFF};
        end
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fu_dispatch_ctrl.sv
// tb_fu_dispatch_ctrl: cycle-exact directed bench with a response scoreboard
module tb_fu_dispatch_ctrl;
  localparam int T = 64;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [31:0] cmd_arg0 = '0, cmd_arg1 = '0, cmd_arg2 = '0;
  logic [31:0] fu_arg0, fu_arg1, fu_arg2;
  logic [2:0] fu_start, fu_done = '0;
  logic [95:0] fu_result = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err, busy;
  logic [31:0] rsp_data;
  logic [7:0] err_count;
  int checks = 0, errors = 0;
  logic [32:0] sb[$];
  fu_dispatch_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(7)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1), .cmd_arg2(cmd_arg2),
    .fu_arg0(fu_arg0), .fu_arg1(fu_arg1), .fu_arg2(fu_arg2), .fu_start(fu_start),
    .fu_done(fu_done), .fu_result(fu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg0 = a0;
    cmd_arg1 = a1;
    cmd_arg2 = a2;
    chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        else begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("sb_data", rsp_data, e[31:0]);
          chk("sb_err", {31'd0, rsp_err}, {31'd0, e[32]});
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_fu_start", {29'd0, fu_start}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_fu_arg0", fu_arg0, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    // exp: done[0] at cycle 9, response at 10
    sb.push_back({1'b0, 32'h8A3D_0000});
    issue(2'd0, 32'h1000_0000, 32'd0, 32'd0);
    for (int c = 1; c <= 9; c++) begin
      chk("t1_ready", {31'd0, cmd_ready}, 32'd0);
      chk("t1_start", {29'd0, fu_start}, c == 1 ? 32'd1 : 32'd0);
      chk("t1_novalid", {31'd0, rsp_valid}, 32'd0);
      if (c == 9) begin
        fu_done = 3'b001;
        fu_result[31:0] = 32'h8A3D_0000;
      end
      @(negedge clk);
    end
    fu_done = '0;
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_rsp_data", rsp_data, 32'h8A3D_0000);
    chk("t1_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("t1_ready10", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    // requant with a 4-cycle response stall
    rsp_ready = 1'b0;
    sb.push_back({1'b0, 32'h0000_0019});
    issue(2'd2, 32'h64, 32'h4000_0000, 32'hFFFF_FFFF);
    for (int c = 1; c <= 5; c++) begin
      chk("t2_start", {29'd0, fu_start}, c == 1 ? 32'd4 : 32'd0);
      if (c >= 2) chk("t2_arg2", fu_arg2, 32'hFFFF_FFFF);
      if (c == 5) begin
        fu_done = 3'b100;
        fu_result[95:64] = 32'h0000_0019;
      end
      @(negedge clk);
    end
    fu_done = '0;
    for (int c = 0; c < 4; c++) begin
      chk("t2_stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t2_stall_data", rsp_data, 32'h0000_0019);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t2_idle", {31'd0, busy}, 32'd0);
    chk("t2_valid_drop", {31'd0, rsp_valid}, 32'd0);
    // illegal op
    sb.push_back({1'b1, 32'hFFFF_FFFF});
    issue(2'd3, 32'h1, 32'h2, 32'h3);
    chk("t3_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t3_data", rsp_data, 32'hFFFF_FFFF);
    chk("t3_err", {31'd0, rsp_err}, 32'd1);
    chk("t3_start", {29'd0, fu_start}, 32'd0);
    chk("t3_err_count", {24'd0, err_count}, 32'd1);
    @(negedge clk);
    chk("t3_start2", {29'd0, fu_start}, 32'd0);
    chk("t3_idle", {31'd0, busy}, 32'd0);
    // reciprocal timeout: WAIT entered at cycle 2, response at 2+T
    sb.push_back({1'b1, 32'hFFFF_FFFF});
    issue(2'd1, 32'h55, 32'd0, 32'd0);
    for (int c = 1; c < 2 + T; c++) begin
      chk("t4_start", {29'd0, fu_start}, c == 1 ? 32'd2 : 32'd0);
      chk("t4_novalid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    chk("t4_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t4_err", {31'd0, rsp_err}, 32'd1);
    chk("t4_data", rsp_data, 32'hFFFF_FFFF);
    chk("t4_err_count", {24'd0, err_count}, 32'd2);
    @(negedge clk);
    fu_done = 3'b010;
    fu_result[63:32] = 32'hAAAA_5555;
    @(negedge clk);
    fu_done = '0;
    for (int c = 0; c < 3; c++) begin
      chk("t4_stray_valid", {31'd0, rsp_valid}, 32'd0);
      chk("t4_stray_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    // reciprocal: wrong-unit done, then right done on the timeout cycle
    sb.push_back({1'b0, 32'h1234_5678});
    issue(2'd1, 32'h77, 32'd0, 32'd0);
    for (int c = 1; c < 2 + T; c++) begin
      chk("t5_novalid", {31'd0, rsp_valid}, 32'd0);
      fu_done = c == 4 ? 3'b001 : c == 1 + T ? 3'b010 : 3'b000;
      fu_result = {32'h0, 32'h1234_5678, 32'hDEAD_BEEF};
      @(negedge clk);
    end
    fu_done = '0;
    chk("t5_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t5_data", rsp_data, 32'h1234_5678);
    chk("t5_err", {31'd0, rsp_err}, 32'd0);
    chk("t5_err_count", {24'd0, err_count}, 32'd2);
    @(negedge clk);
    // reset while waiting, late done ignored, then a clean exp op
    issue(2'd0, 32'h9, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_start", {29'd0, fu_start}, 32'd0);
    chk("t6_err_count_rst", {24'd0, err_count}, 32'd0);
    fu_done = 3'b001;
    @(negedge clk);
    fu_done = '0;
    chk("t6_late_done", {31'd0, busy | rsp_valid}, 32'd0);
    sb.push_back({1'b0, 32'h0BAD_F00D});
    issue(2'd0, 32'h2000_0000, 32'd0, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      chk("t6_start_n", {29'd0, fu_start}, c == 1 ? 32'd1 : 32'd0);
      if (c == 3) begin
        fu_done = 3'b001;
        fu_result[31:0] = 32'h0BAD_F00D;
      end
      @(negedge clk);
    end
    fu_done = '0;
    chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t6_rsp_data", rsp_data, 32'h0BAD_F00D);
    chk("t6_err_count", {24'd0, err_count}, 32'd0);
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
